demux_eight_stream: RTL and testbench

//  Write-side counterpart of the 8:1 mux: routes one 8-bit valid/ready input stream to one of
//  8 output channels chosen by a 3-bit select. Each channel holds one word in its own holding

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 43 ++++
 rtl/demux_eight_stream.sv | 57 +++++
 tb/tb_demux_eight_stream.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared widths and slot state encoding for the 8-channel mux/demux datapath blocks.
package demux_pkg;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int N_CH   = 2 ** SEL_W;
    localparam int CNT_W  = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] one;
        one = {{(N_CH-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a demux output channel; refill on the draining edge keeps it full.
module demux_slot
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              full
);
    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A write is only issued when the slot is empty or draining, so write wins over drain.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d = SLOT_FULL;
            data_d  = wr_data;
        end else if (state_q == SLOT_FULL && rd_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == SLOT_FULL);
    // Full here means "cannot take a word this cycle": holding and not being drained.
    assign full  = valid & ~rd_ready;
endmodule

// File: rtl/demux_eight_stream.sv
// Routes one valid/ready byte stream to one of eight single-entry output channels by select.
module demux_eight_stream
    import demux_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [CNT_W-1:0]         acc_count
);
    logic [N_CH-1:0]  sel_oh;
    logic [N_CH-1:0]  slot_full;
    logic [N_CH-1:0]  wr_en;
    logic             in_fire;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;

    assign sel_oh   = sel_onehot(in_sel);
    // in_ready never looks at in_valid, so producers may wait on it before asserting valid.
    assign in_ready = ~slot_full[in_sel];
    assign in_fire  = in_valid & in_ready;
    assign wr_en    = in_fire ? sel_oh : '0;

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        demux_slot u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[i]),
            .wr_data  (in_data),
            .rd_ready (out_ready[i]),
            .data     (out_data[i*DATA_W +: DATA_W]),
            .valid    (out_valid[i]),
            .full     (slot_full[i])
        );
    end

    always_comb begin
        acc_count_d = acc_count_q;
        if (in_fire) begin
            acc_count_d = acc_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_count_q <= '0;
        end else begin
            acc_count_q <= acc_count_d;
        end
    end

    assign acc_count = acc_count_q;
endmodule

// File: tb/tb_demux_eight_stream.sv
// Directed bench for demux_eight_stream: per-channel expected queues checked by a drain monitor.
module tb_demux_eight_stream;
    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [7:0]  acc_count;

    logic [7:0]  exp_q[8][$];
    logic [7:0]  exp_cnt;
    int          errors;
    int          checks;

    demux_eight_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_count (acc_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int c = 0; c < 8; c++) exp_q[c].delete();
        exp_cnt = 8'd0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    // Monitor: every edge-visible drain pops the channel's expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int c = 0; c < 8; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL drain_ch%0d: got %0h expected no word", c, out_data[c*8 +: 8]);
                    end else begin
                        logic [7:0] e;
                        e = exp_q[c].pop_front();
                        if (out_data[c*8 +: 8] !== e) begin
                            errors++;
                            $display("FAIL drain_ch%0d: got %0h expected %0h", c, out_data[c*8 +: 8], e);
                        end
                    end
                end
            end
        end
    end

    // Driver: hold the word until accepted (bounded), record expectation at the accepting edge.
    task automatic send(input logic [2:0] sel, input logic [7:0] data);
        bit done;
        done = 1'b0;
        in_sel = sel;
        in_data = data;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q[sel].push_back(data);
                exp_cnt++;
                done = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: got no accept expected accept on ch%0d", sel);
        end
    endtask

    // Back-to-back words with consumers ready; in_ready must stay high every cycle.
    task automatic stream(input int n, input bit rotate, input logic [2:0] base, input logic [7:0] dbase);
        logic [2:0] sel, prev_sel;
        prev_sel = base;
        for (int k = 0; k < n; k++) begin
            sel = rotate ? 3'(base + 3'(k)) : base;
            in_sel = sel;
            in_data = 8'(dbase + 8'(k));
            in_valid = 1'b1;
            @(negedge clk);
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
            if (k > 0) check("stream_latency", {63'd0, out_valid[prev_sel]}, 64'd1);
            if (in_ready) begin
                exp_q[sel].push_back(in_data);
                exp_cnt++;
            end
            prev_sel = sel;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_cnt = 8'd0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_sel = 3'd0;
        out_ready = 8'h00;

        // 1: reset with in_valid high
        in_valid = 1'b1;
        in_data = 8'hEE;
        do_reset(2);
        in_valid = 1'b0;
        check("reset_out_valid", {56'd0, out_valid}, 64'h0);
        check("reset_acc_count", {56'd0, acc_count}, 64'h0);
        check("reset_out_data", out_data, 64'h0);

        // 2: single route to ch5
        send(3'd5, 8'hA5);
        check("route_out_valid", {56'd0, out_valid}, 64'h20);
        check("route_ch5_data", {56'd0, out_data[47:40]}, 64'hA5);
        check("route_others", out_data & ~64'h0000_FF00_0000_0000, 64'h0);
        check("route_acc_count", {56'd0, acc_count}, {56'd0, exp_cnt});

        // 3: backpressure then same-cycle refill on ch2
        send(3'd2, 8'h77);
        in_sel = 3'd2;
        in_data = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        step();
        check("bp_ch2_holds", {56'd0, out_data[23:16]}, 64'h77);
        check("bp_ch2_valid", {63'd0, out_valid[2]}, 64'd1);
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("bp_in_ready_drain", {63'd0, in_ready}, 64'd1);
        if (in_ready) begin
            exp_q[2].push_back(8'h3C);
            exp_cnt++;
        end
        step();
        in_valid = 1'b0;
        out_ready[2] = 1'b0;
        check("refill_ch2_valid", {63'd0, out_valid[2]}, 64'd1);
        check("refill_ch2_data", {56'd0, out_data[23:16]}, 64'h3C);
        check("refill_acc_count", {56'd0, acc_count}, {56'd0, exp_cnt});

        // 4: fill all channels, drain all in one cycle
        do_reset(1);
        for (int c = 0; c < 8; c++) send(3'(c), 8'(8'h10 + c));
        check("fill_out_valid", {56'd0, out_valid}, 64'hFF);
        check("fill_out_data", out_data, 64'h1716_1514_1312_1110);
        check("fill_acc_count", {56'd0, acc_count}, 64'd8);
        out_ready = 8'hFF;
        step();
        out_ready = 8'h00;
        check("drain_all_valid", {56'd0, out_valid}, 64'h0);
        check("drain_keeps_data", out_data, 64'h1716_1514_1312_1110);

        // 5: 20 back-to-back words to ch1
        out_ready = 8'h02;
        stream(20, 1'b0, 3'd1, 8'h40);
        out_ready = 8'h00;
        check("tput_acc_count", {56'd0, acc_count}, 64'd28);

        // 6: wrap after 256 accepts, then reset with ch4 full
        do_reset(1);
        out_ready = 8'hFF;
        stream(256, 1'b1, 3'd0, 8'h00);
        out_ready = 8'h00;
        check("wrap_acc_count", {56'd0, acc_count}, 64'd0);
        send(3'd4, 8'h99);
        check("pre_rst_ch4_valid", {56'd0, out_valid}, 64'h10);
        check("pre_rst_acc_count", {56'd0, acc_count}, 64'd1);
        do_reset(1);
        check("mid_rst_out_valid", {56'd0, out_valid}, 64'h0);
        check("mid_rst_acc_count", {56'd0, acc_count}, 64'd0);
        check("mid_rst_out_data", out_data, 64'h0);

        for (int c = 0; c < 8; c++) check("leftover_exp", 64'(exp_q[c].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
